// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board input conditioning front end.
// Channel indices map raw inputs onto the per-channel debounce vector.
package input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_WIDTH_DEF       = 19;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    localparam int NUM_CH     = 5;
    localparam int CH_LEFT    = 0;
    localparam int CH_RIGHT   = 1;
    localparam int CH_RELEASE = 2;
    localparam int CH_PAUSE   = 3;
    localparam int CH_IGNORE  = 4;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: two-flop synchroniser followed by a stability counter.
// RISE pulses for one cycle after the debounced level goes from 0 to 1.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RAW,
    output logic LEVEL,
    output logic RISE
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 s_q;
    logic                 s_d;
    logic                 s_prev_q;
    logic [CNT_WIDTH-1:0] c_q;
    logic [CNT_WIDTH-1:0] c_d;

    always_comb begin
        s_d = s_q;
        c_d = '0;
        if (sync2_q != s_q) begin
            if (c_q == LAST) begin
                s_d = sync2_q;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
            c_q      <= '0;
        end else begin
            sync1_q  <= RAW;
            sync2_q  <= sync1_q;
            s_q      <= s_d;
            s_prev_q <= s_q;
            c_q      <= c_d;
        end
    end

    assign LEVEL = s_q;
    assign RISE  = s_q & ~s_prev_q;

endmodule

// File: rtl/input_conditioner.sv
// Clean, synchronous button and switch levels for the game controller.
// Release is latched until an unpaused physics update consumes it.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_LEFT_RAW,
    input  logic BTN_RIGHT_RAW,
    input  logic BTN_RELEASE_RAW,
    input  logic SW_PAUSE_RAW,
    input  logic SW_IGNORE_DEATH_RAW,
    input  logic FRAME_RENDERED,
    output logic BTN_LEFT,
    output logic BTN_RIGHT,
    output logic BTN_RELEASE,
    output logic SW_PAUSE,
    output logic SW_IGNORE_DEATH
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] rise;
    logic              unused_rise;

    logic left_q;
    logic right_q;
    logic pause_q;
    logic ignore_q;
    logic pend_q;
    logic pend_d;

    assign raw[CH_LEFT]    = BTN_LEFT_RAW;
    assign raw[CH_RIGHT]   = BTN_RIGHT_RAW;
    assign raw[CH_RELEASE] = BTN_RELEASE_RAW;
    assign raw[CH_PAUSE]   = SW_PAUSE_RAW;
    assign raw[CH_IGNORE]  = SW_IGNORE_DEATH_RAW;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_deb (
            .CLK  (CLK),
            .RESET(RESET),
            .RAW  (raw[i]),
            .LEVEL(lvl[i]),
            .RISE (rise[i])
        );
    end

    assign unused_rise = ^{rise[CH_IGNORE], rise[CH_PAUSE],
                           rise[CH_RIGHT], rise[CH_LEFT]};

    // Set beats clear so a press landing on an update is never lost.
    always_comb begin
        pend_d = pend_q;
        if (FRAME_RENDERED && !pause_q) begin
            pend_d = 1'b0;
        end
        if (rise[CH_RELEASE]) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            pause_q  <= 1'b0;
            ignore_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            left_q   <= lvl[CH_LEFT] & ~lvl[CH_RIGHT];
            right_q  <= lvl[CH_RIGHT] & ~lvl[CH_LEFT];
            pause_q  <= lvl[CH_PAUSE];
            ignore_q <= lvl[CH_IGNORE];
            pend_q   <= pend_d;
        end
    end

    assign BTN_LEFT        = left_q;
    assign BTN_RIGHT       = right_q;
    assign BTN_RELEASE     = pend_q;
    assign SW_PAUSE        = pause_q;
    assign SW_IGNORE_DEATH = ignore_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce window.
// Raw vector order: {ignore, pause, release, right, left}.
module tb_input_conditioner;

    localparam int N = 4;

    typedef struct {
        logic [4:0] raw;
        logic       fr;
        int         n;
        logic [4:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;
    logic [4:0] raw_in;
    logic FR;
    logic BTN_LEFT, BTN_RIGHT, BTN_RELEASE, SW_PAUSE, SW_IGNORE_DEATH;
    logic [4:0] dut_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0] mh [N+1];
    logic [4:0] m_s;
    logic       m_rel_prev;
    logic       m_p;
    logic [4:0] m_out;

    vec_t tbl[$];

    always #5 CLK = ~CLK;

    input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_WIDTH      (3)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .BTN_LEFT_RAW       (raw_in[0]),
        .BTN_RIGHT_RAW      (raw_in[1]),
        .BTN_RELEASE_RAW    (raw_in[2]),
        .SW_PAUSE_RAW       (raw_in[3]),
        .SW_IGNORE_DEATH_RAW(raw_in[4]),
        .FRAME_RENDERED     (FR),
        .BTN_LEFT           (BTN_LEFT),
        .BTN_RIGHT          (BTN_RIGHT),
        .BTN_RELEASE        (BTN_RELEASE),
        .SW_PAUSE           (SW_PAUSE),
        .SW_IGNORE_DEATH    (SW_IGNORE_DEATH)
    );

    assign dut_out = {SW_IGNORE_DEATH, SW_PAUSE, BTN_RELEASE,
                      BTN_RIGHT, BTN_LEFT};

    function automatic vec_t mkv(logic [4:0] r, logic f, int n,
                                 logic [4:0] e);
        vec_t v;
        v.raw = r;
        v.fr  = f;
        v.n   = n;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= N; k++) mh[k] = '0;
        m_s        = '0;
        m_rel_prev = 1'b0;
        m_p        = 1'b0;
        m_out      = '0;
    endtask

    // A level flips once the last N synchronised samples all disagree.
    task automatic model_edge(logic [4:0] r, logic f);
        logic [4:0] s_new;
        logic       all_diff;
        logic       rise;
        s_new = m_s;
        for (int ch = 0; ch < 5; ch++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= N; k++)
                if (mh[k][ch] == m_s[ch]) all_diff = 1'b0;
            if (all_diff) s_new[ch] = ~m_s[ch];
        end
        rise = m_s[2] & ~m_rel_prev;
        if (rise) m_p = 1'b1;
        else if (f && !m_out[3]) m_p = 1'b0;
        m_out = {m_s[4], m_s[3], m_p, m_s[1] & ~m_s[0], m_s[0] & ~m_s[1]};
        m_rel_prev = m_s[2];
        m_s = s_new;
        for (int k = N; k >= 1; k--) mh[k] = mh[k-1];
        mh[0] = r;
    endtask

    task automatic tick(logic [4:0] r, logic f);
        raw_in = r;
        FR     = f;
        @(posedge CLK);
        model_edge(r, f);
        @(negedge CLK);
        chk("model", dut_out, m_out);
    endtask

    task automatic do_reset(logic [4:0] r);
        RESET  = 1'b1;
        raw_in = r;
        FR     = 1'b0;
        #1;
        chk("reset_async", dut_out, 5'b00000);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_hold", dut_out, 5'b00000);
        RESET = 1'b0;
    endtask

    initial begin
        tbl.push_back(mkv(5'h00, 0, 8,   5'h00));
        tbl.push_back(mkv(5'h01, 0, 3,   5'h00));
        tbl.push_back(mkv(5'h00, 0, 1,   5'h00));
        tbl.push_back(mkv(5'h01, 0, 3,   5'h00));
        tbl.push_back(mkv(5'h00, 0, 8,   5'h00));
        tbl.push_back(mkv(5'h01, 0, 6,   5'h00));
        tbl.push_back(mkv(5'h01, 0, 1,   5'h01));
        tbl.push_back(mkv(5'h03, 0, 6,   5'h01));
        tbl.push_back(mkv(5'h03, 0, 1,   5'h00));
        tbl.push_back(mkv(5'h02, 0, 6,   5'h00));
        tbl.push_back(mkv(5'h02, 0, 1,   5'h02));
        tbl.push_back(mkv(5'h00, 0, 7,   5'h00));
        tbl.push_back(mkv(5'h04, 0, 7,   5'h04));
        tbl.push_back(mkv(5'h04, 0, 100, 5'h04));
        tbl.push_back(mkv(5'h04, 1, 1,   5'h00));
        tbl.push_back(mkv(5'h04, 0, 20,  5'h00));
        tbl.push_back(mkv(5'h00, 0, 8,   5'h00));
        tbl.push_back(mkv(5'h08, 0, 7,   5'h08));
        tbl.push_back(mkv(5'h0C, 0, 7,   5'h0C));
        tbl.push_back(mkv(5'h0C, 1, 1,   5'h0C));
        tbl.push_back(mkv(5'h0C, 0, 3,   5'h0C));
        tbl.push_back(mkv(5'h0C, 1, 1,   5'h0C));
        tbl.push_back(mkv(5'h04, 0, 7,   5'h04));
        tbl.push_back(mkv(5'h04, 1, 1,   5'h00));
        tbl.push_back(mkv(5'h00, 0, 8,   5'h00));
        tbl.push_back(mkv(5'h04, 0, 6,   5'h00));
        tbl.push_back(mkv(5'h04, 1, 1,   5'h04));
        tbl.push_back(mkv(5'h04, 0, 5,   5'h04));
        tbl.push_back(mkv(5'h04, 1, 1,   5'h00));
        tbl.push_back(mkv(5'h10, 0, 7,   5'h10));
        tbl.push_back(mkv(5'h00, 0, 8,   5'h00));
        tbl.push_back(mkv(5'h04, 0, 7,   5'h04));

        RESET  = 1'b1;
        raw_in = 5'h1F;
        FR     = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_all_high", dut_out, 5'b00000);
        RESET = 1'b0;

        // Left rises exactly seven clocks after reset release
        for (int k = 1; k <= 7; k++) begin
            tick(5'b11101, 1'b0);
            if (k < 7) chk("t1_early", dut_out, 5'b00000);
            else       chk("t1_latency", dut_out, 5'b11101);
        end

        do_reset(5'h00);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) tick(tbl[i].raw, tbl[i].fr);
            chk($sformatf("tbl%0d", i), dut_out, tbl[i].exp);
        end

        // Reset while release is pending drops everything at once
        do_reset(5'h04);
        for (int c = 0; c < 3; c++) tick(5'h04, 1'b0);
        chk("post_reset", dut_out, 5'b00000);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] r;
            r = raw_in;
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            if (i == 1500) do_reset(r);
            tick(r, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end stage directly upstream of GameController. It takes raw asynchronous board buttons and switches and produces the clean, clock-domain-safe BTN_LEFT, BTN_RIGHT, BTN_RELEASE, SW_PAUSE and SW_IGNORE_DEATH levels the game logic consumes. Each input is synchronised and debounced. The release button is converted into a sticky request that is held until a physics update has actually consumed it.

Parameters:
DEBOUNCE_CYCLES, 500000, stable-input cycles required before a debounced level changes (10 ms at 50 MHz); legal range 2 or more.
CNT_WIDTH, 19, counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
CLK  in  1  system clock; single clock domain.
RESET  in  1  asynchronous, active-high reset.
BTN_LEFT_RAW  in  1  raw left pushbutton, asynchronous, active-high.
BTN_RIGHT_RAW  in  1  raw right pushbutton, asynchronous, active-high.
BTN_RELEASE_RAW  in  1  raw ball-release pushbutton, asynchronous, active-high.
SW_PAUSE_RAW  in  1  raw pause slide switch.
SW_IGNORE_DEATH_RAW  in  1  raw ignore-death slide switch.
FRAME_RENDERED  in  1  one-cycle strobe from the video stage marking the start of a physics update.
BTN_LEFT  out  1  debounced left level, gated for conflicts.
BTN_RIGHT  out  1  debounced right level, gated for conflicts.
BTN_RELEASE  out  1  sticky release request.
SW_PAUSE  out  1  debounced pause level.
SW_IGNORE_DEATH  out  1  debounced ignore-death level.

Behaviour:
- Reset:
  - Asserting RESET asynchronously clears all synchroniser flops, debounced states, counters and the release-pending flag.
  - All outputs are 0 while RESET is high and on the first clock after release.
  - Reset mid-debounce discards the partial count.
- Synchroniser: each raw input passes through 2 flops (sync1, sync2) reset to 0. No logic sits between sync1 and sync2.
- Debounce, per channel (stable register S, counter C):
  - If sync2 == S: C <= 0.
  - If sync2 != S and C < DEBOUNCE_CYCLES-1: C <= C+1.
  - If sync2 != S and C == DEBOUNCE_CYCLES-1: S <= sync2, C <= 0.
  - Any glitch back to S before the count completes restarts the count from 0.
  - Counter never wraps.
  - Latency from a clean raw edge to the S change: 2 + DEBOUNCE_CYCLES clocks.
- Direction outputs:
  - BTN_LEFT = S_left & ~S_right; BTN_RIGHT = S_right & ~S_left. Both pressed gives both outputs 0.
  - Both outputs are registered, adding 1 clock.
- SW_PAUSE and SW_IGNORE_DEATH are registered copies of their S, adding 1 clock.
- Release request (pending flag P):
  - Rising edge of S_release (S = 1 and previous S = 0) is a set event. A held button produces exactly one set.
  - Clear event: FRAME_RENDERED = 1 and SW_PAUSE = 0 (registered pause value). While paused, the request is kept until an update really runs.
  - Set and clear in the same cycle: set wins, so P is 1 next cycle.
  - When P is already 1, the clear in that cycle is still observed by GameController with BTN_RELEASE = 1, because P drops only on the following edge.
  - BTN_RELEASE = P, registered, with no extra stage.
- FRAME_RENDERED is already synchronous to CLK and is not synchronised or debounced.

Decomposition:
- Shared package: default DEBOUNCE_CYCLES and CNT_WIDTH constants, plus a simulation override constant of 4.
- One natural sub-module, debounce_channel (synchroniser + S + C; ports CLK, RESET, RAW, LEVEL, RISE), instantiated 5 times.
- Conflict gating and the release flag stay in input_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
1. Assert RESET with all raw inputs = 1, then release -> all outputs 0 at reset release. BTN_LEFT rises exactly 2+4+1 = 7 clocks later.
2. Toggle BTN_LEFT_RAW as 1 for 3 clocks, 0 for 1, 1 for 3, then 0 -> BTN_LEFT never asserts. Holding 1 for 6 or more clocks asserts it.
3. Left held and debounced, then right pressed and debounced -> BTN_LEFT falls to 0 and BTN_RIGHT stays 0. Releasing left -> BTN_RIGHT = 1 after 2+4+1 clocks.
4. Press release and hold 100 clocks with no FRAME_RENDERED -> BTN_RELEASE = 1 throughout. A FRAME_RENDERED pulse clears it 1 clock later. It does not re-set while still held.
5. SW_PAUSE = 1 debounced, release pressed, FRAME_RENDERED pulses twice -> BTN_RELEASE stays 1. Un-pause, next FRAME_RENDERED -> it clears.
6. Release rising edge in the same cycle as FRAME_RENDERED with P = 0 -> BTN_RELEASE = 1 next cycle and held until the following FRAME_RENDERED. RESET asserted mid-hold -> immediate 0.
